// File: rtl/kbd_spi_matrix.sv
// kbd_spi_matrix: SPI-slave receiver for the keyboard controller link.
// Frames arrive MSB first under KBD_CS as 8 rows x 5 columns (col 4..0)
// followed by a status byte. A frame is committed to the matrix/status
// registers only if exactly FRAME_BITS bits arrived before KBD_CS rises.
// The committed matrix feeds the port #FE read byte combinationally.
module kbd_spi_matrix #(
    parameter int FRAME_BITS = 48,
    parameter int TIMEOUT_W  = 12
) (
    input  logic       CLK_14MHZ,
    input  logic       CPU_RESET,
    input  logic       KBD_CLK,
    input  logic       KBD_CS,
    input  logic       KBD_DI,
    input  logic       TAPE_IN,
    input  logic [7:0] A_HI,
    output logic [7:0] fe_data,
    output logic       kbd_reset_req,
    output logic       kbd_turbo,
    output logic       kbd_magic,
    output logic       frame_ok,
    output logic       frame_err
);

    localparam logic [6:0] CNT_FULL = 7'(FRAME_BITS);
    localparam logic [6:0] CNT_SAT  = 7'(FRAME_BITS + 1);
    localparam logic [TIMEOUT_W-1:0] TIMER_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_ABORT
    } state_t;

    // [0] first sync stage, [1] synchronized value, [2] previous value for edges
    logic [2:0] clk_sync_reg;
    logic [2:0] cs_sync_reg;
    logic [1:0] di_sync_reg;
    logic [1:0] tape_sync_reg;

    state_t                  state_reg;
    logic [6:0]              bit_cnt_reg;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [TIMEOUT_W-1:0]    timer_reg;
    logic [4:0]              matrix_reg [8];
    logic [2:0]              status_reg;
    logic                    frame_ok_reg;
    logic                    frame_err_reg;

    logic       clk_rise;
    logic       cs_fall;
    logic       cs_rise;
    logic [4:0] row_term [8];
    logic [4:0] kd;

    assign clk_rise = clk_sync_reg[1] & ~clk_sync_reg[2];
    assign cs_fall  = ~cs_sync_reg[1] & cs_sync_reg[2];
    assign cs_rise  = cs_sync_reg[1] & ~cs_sync_reg[2];

    // Bring the asynchronous controller and tape signals into CLK_14MHZ
    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            clk_sync_reg  <= 3'b111;
            cs_sync_reg   <= 3'b111;
            di_sync_reg   <= 2'b00;
            tape_sync_reg <= 2'b11;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[1:0], KBD_CLK};
            cs_sync_reg   <= {cs_sync_reg[1:0], KBD_CS};
            di_sync_reg   <= {di_sync_reg[0], KBD_DI};
            tape_sync_reg <= {tape_sync_reg[0], TAPE_IN};
        end
    end

    // Frame receiver: shift, length check on CS rise, inactivity abort
    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            timer_reg     <= '0;
            status_reg    <= '0;
            frame_ok_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            for (int r = 0; r < 8; r++) begin
                matrix_reg[r] <= 5'b11111;
            end
        end else begin
            frame_ok_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            if (cs_fall) begin
                // A new frame always restarts reception, whatever came before
                state_reg   <= ST_RECV;
                bit_cnt_reg <= '0;
                shift_reg   <= '0;
                timer_reg   <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg <= ST_IDLE;
                    end
                    ST_RECV: begin
                        if (cs_rise) begin
                            // A coincident clock rise is dropped; length is judged as-is
                            if (bit_cnt_reg == CNT_FULL) begin
                                for (int r = 0; r < 8; r++) begin
                                    matrix_reg[r] <= shift_reg[FRAME_BITS-1-5*r -: 5];
                                end
                                status_reg   <= shift_reg[2:0];
                                frame_ok_reg <= 1'b1;
                            end else begin
                                frame_err_reg <= 1'b1;
                            end
                            state_reg <= ST_IDLE;
                        end else if (clk_rise && !cs_sync_reg[1]) begin
                            shift_reg <= {shift_reg[FRAME_BITS-2:0], di_sync_reg[1]};
                            if (bit_cnt_reg != CNT_SAT) begin
                                bit_cnt_reg <= bit_cnt_reg + 7'd1;
                            end
                            timer_reg <= '0;
                        end else if (timer_reg == '1) begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= ST_ABORT;
                        end else begin
                            timer_reg <= timer_reg + TIMER_ONE;
                        end
                    end
                    ST_ABORT: begin
                        // The error was already reported; just wait for CS to close
                        if (cs_rise) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // A deselected row (A_HI bit high) contributes all-ones to the column AND
    for (genvar gi = 0; gi < 8; gi++) begin : g_row
        assign row_term[gi] = A_HI[gi] ? 5'b11111 : matrix_reg[gi];
    end

    // Combine all selected rows; a pressed key (0) in any of them pulls its column low
    always_comb begin
        kd = 5'b11111;
        for (int r = 0; r < 8; r++) begin
            kd = kd & row_term[r];
        end
    end

    assign fe_data       = {1'b1, tape_sync_reg[1], 1'b1, kd};
    assign kbd_reset_req = status_reg[0];
    assign kbd_turbo     = status_reg[1];
    assign kbd_magic     = status_reg[2];
    assign frame_ok      = frame_ok_reg;
    assign frame_err     = frame_err_reg;

endmodule

// File: tb/tb_kbd_spi_matrix.sv
// tb_kbd_spi_matrix: directed frames against a matrix-level model of the
// keyboard link, checked every cycle plus literal spot checks.
`timescale 1ns/1ps
module tb_kbd_spi_matrix;

    logic       clk_14mhz;
    logic       cpu_reset;
    logic       kbd_clk;
    logic       kbd_cs;
    logic       kbd_di;
    logic       tape_in;
    logic [7:0] a_hi;
    logic [7:0] fe_data;
    logic       kbd_reset_req;
    logic       kbd_turbo;
    logic       kbd_magic;
    logic       frame_ok;
    logic       frame_err;

    kbd_spi_matrix #(.FRAME_BITS(48), .TIMEOUT_W(12)) dut (
        .CLK_14MHZ    (clk_14mhz),
        .CPU_RESET    (cpu_reset),
        .KBD_CLK      (kbd_clk),
        .KBD_CS       (kbd_cs),
        .KBD_DI       (kbd_di),
        .TAPE_IN      (tape_in),
        .A_HI         (a_hi),
        .fe_data      (fe_data),
        .kbd_reset_req(kbd_reset_req),
        .kbd_turbo    (kbd_turbo),
        .kbd_magic    (kbd_magic),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err)
    );

    initial clk_14mhz = 1'b0;
    always #5 clk_14mhz = ~clk_14mhz;

    int compared   = 0;
    int mismatched = 0;

    // Model: committed key matrix/status, expected pulses and tape level
    logic [4:0] m_rows [8];
    logic [2:0] m_status;
    logic       exp_ok;
    logic       exp_err;
    logic       exp_tape;
    logic       cmp_en;

    // Frame under construction by the stimulus
    logic [4:0] p_rows [8];
    logic [7:0] p_status;
    logic       bitq [$];

    logic [7:0] a_tab [14] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF,
                               8'h7F, 8'hFF, 8'h00, 8'h7E, 8'hD7, 8'hAA, 8'h55};
    int a_idx = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] model_kd(input logic [7:0] a);
        logic [4:0] k;
        k = 5'b11111;
        for (int r = 0; r < 8; r++) begin
            if (!a[r]) k = k & m_rows[r];
        end
        return k;
    endfunction

    // Per-cycle comparison of every output against the model
    always @(negedge clk_14mhz) begin
        if (cmp_en) begin
            chk("fe_data", fe_data, {1'b1, exp_tape, 1'b1, model_kd(a_hi)});
            chk("status", {5'b0, kbd_magic, kbd_turbo, kbd_reset_req}, {5'b0, m_status});
            chk("pulses", {6'b0, frame_ok, frame_err}, {6'b0, exp_ok, exp_err});
        end
    end

    task automatic tick();
        @(posedge clk_14mhz);
        #2;
        a_hi  = a_tab[a_idx];
        a_idx = (a_idx + 1) % 14;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++) m_rows[r] = 5'b11111;
        m_status = 3'b000;
    endtask

    task automatic set_rows_idle();
        for (int r = 0; r < 8; r++) p_rows[r] = 5'b11111;
    endtask

    task automatic build_bits(input int nbits);
        bitq.delete();
        for (int r = 0; r < 8; r++)
            for (int c = 4; c >= 0; c--) bitq.push_back(p_rows[r][c]);
        for (int b = 7; b >= 0; b--) bitq.push_back(p_status[b]);
        while (bitq.size() < nbits) bitq.push_back(1'b0);
    endtask

    task automatic cs_low();
        tick();
        kbd_cs = 1'b0;
    endtask

    task automatic clk_bit(input logic b);
        kbd_di = b;
        repeat (4) tick();
        kbd_clk = 1'b1;
        repeat (4) tick();
        kbd_clk = 1'b0;
    endtask

    // Raise CS and expect the commit (kind 1) or discard (kind 2) on the 3rd edge
    task automatic cs_close(input int kind);
        tick();
        kbd_cs = 1'b1;
        repeat (3) tick();
        if (kind == 1) begin
            chk("frame_ok_edge", {7'b0, frame_ok}, 8'h01);
            m_rows   = p_rows;
            m_status = p_status[2:0];
            exp_ok   = 1'b1;
        end else begin
            chk("frame_err_edge", {7'b0, frame_err}, 8'h01);
            exp_err = 1'b1;
        end
        tick();
        exp_ok  = 1'b0;
        exp_err = 1'b0;
        repeat (4) tick();
    endtask

    task automatic send_frame(input int nbits, input int kind);
        build_bits(nbits);
        cs_low();
        repeat (4) tick();
        for (int i = 0; i < nbits; i++) clk_bit(bitq[i]);
        repeat (4) tick();
        cs_close(kind);
    endtask

    task automatic spot(input string name, input logic [7:0] a, input logic [7:0] exp);
        tick();
        a_hi = a;
        #1;
        chk(name, fe_data, exp);
    endtask

    task automatic frame_a();
        set_rows_idle();
        p_rows[0] = 5'b11110;
        p_rows[7] = 5'b11101;
        p_status  = 8'h02;
    endtask

    initial begin
        cpu_reset = 1'b0;
        kbd_clk   = 1'b0;
        kbd_cs    = 1'b1;
        kbd_di    = 1'b0;
        tape_in   = 1'b1;
        a_hi      = 8'hFF;
        exp_ok    = 1'b0;
        exp_err   = 1'b0;
        exp_tape  = 1'b1;
        cmp_en    = 1'b0;
        model_reset();
        set_rows_idle();
        p_status = 8'h00;

        repeat (3) tick();
        cmp_en = 1'b1;
        repeat (2) tick();
        cpu_reset = 1'b1;
        repeat (3) tick();

        // Reset state
        spot("reset_fe", 8'hFE, 8'hFF);
        chk("reset_status", {5'b0, kbd_magic, kbd_turbo, kbd_reset_req}, 8'h00);
        chk("reset_pulses", {6'b0, frame_ok, frame_err}, 8'h00);

        // Valid frame: CAPS in row 0, SYM in row 7, turbo set
        frame_a();
        send_frame(48, 1);
        spot("caps_fe", 8'hFE, 8'hFE);
        spot("sym_7f", 8'h7F, 8'hFD);
        spot("both_7e", 8'h7E, 8'hFC);
        spot("none_ff", 8'hFF, 8'hFF);
        chk("turbo_on", {7'b0, kbd_turbo}, 8'h01);

        // Short and long frames are discarded
        for (int r = 0; r < 8; r++) p_rows[r] = 5'b00000;
        p_status = 8'hFF;
        send_frame(47, 2);
        spot("after47_all", 8'h00, 8'hFC);
        chk("after47_turbo", {5'b0, kbd_magic, kbd_turbo, kbd_reset_req}, 8'h02);
        send_frame(49, 2);
        spot("after49_all", 8'h00, 8'hFC);
        chk("after49_turbo", {5'b0, kbd_magic, kbd_turbo, kbd_reset_req}, 8'h02);

        // Inactivity abort: CS low without clocks
        cs_low();
        repeat (4099) tick();
        chk("timeout_err", {7'b0, frame_err}, 8'h01);
        exp_err = 1'b1;
        tick();
        exp_err = 1'b0;
        repeat (10) tick();
        tick();
        kbd_cs = 1'b1;
        repeat (3) tick();
        chk("abort_close_quiet", {6'b0, frame_ok, frame_err}, 8'h00);
        repeat (6) tick();

        // Next valid frame commits normally; upper status bits ignored
        set_rows_idle();
        p_rows[3] = 5'b01111;
        p_rows[5] = 5'b10101;
        p_status  = 8'hFD;
        send_frame(48, 1);
        spot("row3_f7", 8'hF7, 8'hEF);
        spot("rows35_d7", 8'hD7, 8'hE5);
        spot("all_00", 8'h00, 8'hE5);
        chk("status_fd", {5'b0, kbd_magic, kbd_turbo, kbd_reset_req}, 8'h05);

        // Tape input reaches bit 6 after two clocks
        tick();
        a_hi = 8'hFF;
        tape_in = 1'b0;
        tick();
        chk("tape_1clk", fe_data, 8'hFF);
        tick();
        exp_tape = 1'b0;
        chk("tape_2clk", fe_data, 8'hBF);
        repeat (3) tick();
        tape_in = 1'b1;
        tick();
        tick();
        exp_tape = 1'b1;
        chk("tape_back", {7'b0, fe_data[6]}, 8'h01);
        repeat (3) tick();

        // Reset mid-frame
        frame_a();
        build_bits(48);
        cs_low();
        repeat (4) tick();
        for (int i = 0; i < 20; i++) clk_bit(bitq[i]);
        tick();
        cpu_reset = 1'b0;
        a_hi = 8'hF7;
        model_reset();
        #1;
        chk("midreset_fe", fe_data, 8'hFF);
        chk("midreset_status", {5'b0, kbd_magic, kbd_turbo, kbd_reset_req}, 8'h00);
        kbd_cs = 1'b1;
        repeat (5) tick();
        cpu_reset = 1'b1;
        repeat (5) tick();
        spot("postreset_fe", 8'hFE, 8'hFF);
        send_frame(48, 1);
        spot("recommit_fe", 8'hFE, 8'hFE);
        chk("recommit_turbo", {7'b0, kbd_turbo}, 8'h01);
        repeat (5) tick();

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
